// File: rtl/color_freq_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : color_freq_sequencer_pkg
// Purpose  : Shared types and constants for the color frequency sequencer.
//            Holds the sweep FSM state encoding, the four filter_sel channel
//            codes (S3:S2) and a small helper for counter sizing.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package color_freq_sequencer_pkg;

  // Sweep FSM states, 2-bit explicit encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GATE   = 2'd2,
    ST_LATCH  = 2'd3
  } state_t;

  // Sensor filter select codes, also the sweep order.
  localparam logic [1:0] CH_RED   = 2'b00;
  localparam logic [1:0] CH_BLUE  = 2'b01;
  localparam logic [1:0] CH_CLEAR = 2'b10;
  localparam logic [1:0] CH_GREEN = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/color_freq_sequencer_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : edge_sync
// Purpose  : Two-flop synchronizer for an asynchronous input followed by a
//            rising-edge detector producing a one-cycle pulse.
// Ports    : clk        - system clock
//            reset      - synchronous active-high reset
//            async_in   - asynchronous input (sensor square wave)
//            edge_pulse - one-cycle pulse per synchronized rising edge
// Revision : 1.0 - initial release
// ============================================================================
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic edge_pulse
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= async_in;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  // Only the second synchronizer stage is considered stable.
  assign edge_pulse = sync2 & ~sync2_d;

endmodule
`default_nettype wire

// File: rtl/color_freq_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : color_freq_sequencer
// Purpose  : Sweeps a color sensor through its four filters (red, blue,
//            clear, green). Per channel: wait SETTLE_CYCLES after switching
//            the filter, count sensor rising edges for GATE_CYCLES, then
//            latch the saturating count as the channel result.
// Ports    : clk          - system clock (rising edge)
//            reset        - synchronous active-high reset, aborts a sweep
//            start        - one-cycle pulse, starts one sweep (ignored if busy)
//            continuous   - restart a new sweep after each completed sweep
//            sensor_freq  - asynchronous sensor square wave
//            filter_sel   - filter select S3:S2 (current channel)
//            result       - edge count of last completed window
//            result_ch    - channel that produced result
//            result_valid - one-cycle pulse when result updates
//            overflow     - count saturated in the reported window
//            busy         - high whenever not idle
// Revision : 1.0 - initial release
// ============================================================================
module color_freq_sequencer
  import color_freq_sequencer_pkg::*;
#(
  parameter int GATE_CYCLES   = 50000,
  parameter int SETTLE_CYCLES = 5000,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic             sensor_freq,
  output logic [1:0]       filter_sel,
  output logic [CNT_W-1:0] result,
  output logic [1:0]       result_ch,
  output logic             result_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int CYC_MAX = max_int(GATE_CYCLES, SETTLE_CYCLES);
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] GATE_LAST   = CYC_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t             state;
  state_t             state_next;
  logic [1:0]         ch_idx;
  logic [CYC_W-1:0]   cyc_cnt;
  logic [CNT_W-1:0]   edge_cnt;
  logic               win_ovf;
  logic               edge_pulse;

  edge_sync u_edge_sync (
    .clk        (clk),
    .reset      (reset),
    .async_in   (sensor_freq),
    .edge_pulse (edge_pulse)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // --------------------------------------------------------------------------
  // FSM next state and status
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE:   if (start || continuous)    state_next = ST_SETTLE;
      ST_SETTLE: if (cyc_cnt == SETTLE_LAST) state_next = ST_GATE;
      ST_GATE:   if (cyc_cnt == GATE_LAST)   state_next = ST_LATCH;
      ST_LATCH:  state_next = ((ch_idx != CH_GREEN) || continuous) ? ST_SETTLE : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: cycle timer, edge counter, channel index, result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_idx       <= CH_RED;
      cyc_cnt      <= '0;
      edge_cnt     <= '0;
      win_ovf      <= 1'b0;
      result       <= '0;
      result_ch    <= CH_RED;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      // The pulse lands in the cycle after LATCH, alongside the new result.
      result_valid <= (state == ST_LATCH);
      case (state)
        ST_IDLE: begin
          if (state_next == ST_SETTLE) begin
            ch_idx  <= CH_RED;
            cyc_cnt <= '0;
          end
        end
        ST_SETTLE: begin
          if (cyc_cnt == SETTLE_LAST) begin
            cyc_cnt  <= '0;
            edge_cnt <= '0;
            win_ovf  <= 1'b0;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        ST_GATE: begin
          // Saturate instead of wrapping; flag the window as overflowed.
          if (edge_pulse) begin
            if (edge_cnt == CNT_MAX) win_ovf  <= 1'b1;
            else                     edge_cnt <= edge_cnt + 1'b1;
          end
          if (cyc_cnt == GATE_LAST) cyc_cnt <= '0;
          else                      cyc_cnt <= cyc_cnt + 1'b1;
        end
        ST_LATCH: begin
          result    <= edge_cnt;
          result_ch <= ch_idx;
          overflow  <= win_ovf;
          cyc_cnt   <= '0;
          // After green, restart only in continuous mode; otherwise the
          // filter stays on green while idle.
          if (ch_idx != CH_GREEN) ch_idx <= ch_idx + 1'b1;
          else if (continuous)    ch_idx <= CH_RED;
        end
        default: ;
      endcase
    end
  end

  assign filter_sel = ch_idx;

endmodule
`default_nettype wire
